spmv_hbm_resp_mem: RTL
======================

# spmv_hbm_resp_mem

BRAM-backed AXI4 responder standing in for one HBM pseudo-channel, on the subordinate side of the ColXi and Val manager ports driven by the SpMV kernels and the Val crossbar. It accepts INCR read and write bursts of 256-bit beats and serves them from an on-chip word array. Read and write channels run independently through separate state machines. It is used in block/system simulation and in reduced builds without HBM.

## Interface
- ADDR_W, 48, AXI address width
- DATA_W, 256, beat width; fixed 256, so a beat is 32 bytes
- DEPTH, 4096, memory depth in 256-bit words; power of two
- clk  in  1  sole clock; all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- s_axi_araddr/arburst/arlen/arsize/arvalid  in  48/2/8/3/1  read address channel
- s_axi_arready  out  1
- s_axi_rdata/rresp/rlast/rvalid  out  256/2/1/1  read data channel
- s_axi_rready  in  1
- s_axi_awaddr/awburst/awlen/awsize/awvalid  in  48/2/8/3/1  write address channel
- s_axi_awready  out  1
- s_axi_wdata/wstrb/wlast/wvalid  in  256/32/1/1  write data channel
- s_axi_wready  out  1
- s_axi_bresp/bvalid  out  2/1  write response channel
- s_axi_bready  in  1

## Operation
- Word index = addr[5+log2(DEPTH)-1:5]; upper bits ignored, so addresses wrap modulo DEPTH words; addr[4:0] ignored. Increment per beat wraps from DEPTH-1 to 0.
- Legal request: burst==2'b01 (INCR) and size==3'd5. Anything else is an error burst.
- Read FSM: R_IDLE -> R_BURST on AR handshake; captures index, len, error flag. Returns exactly arlen+1 beats; rlast on the final beat only; R_BURST -> R_IDLE when the final beat handshakes.
- Read data: rresp=2'b00 and memory contents for legal bursts; rresp=2'b10 and rdata=0 for every beat of an error burst.
- Read path: 1-cycle registered RAM read feeding a 2-entry output buffer, so rready low stalls without losing or duplicating beats.
- Write FSM: W_IDLE -> W_DATA on AW handshake; W_DATA consumes exactly awlen+1 beats; -> W_RESP after the final beat; W_RESP -> W_IDLE on B handshake.
- Write beats: each accepted beat writes bytes with wstrb[i]=1; other bytes are unchanged. Beats of an error burst are consumed but not written.
- bresp=2'b10 if the burst was an error burst, or if wlast on any beat differs from (beat==awlen). Otherwise bresp=2'b00. Beat count, not wlast, ends the burst.
- Same-word read and write in one cycle: read returns old data (read-first).
- Memory contents are not cleared by reset.

## Timing
- While rstn=0 and in the cycle it is sampled: both FSMs go idle, buffer empties, and every output is 0 (arready, awready, wready, rvalid, rlast, rdata, rresp, bvalid, bresp).
- arready=1 exactly when rstn=1 and in R_IDLE; awready=1 exactly when rstn=1 and in W_IDLE. Hence at most one outstanding burst per direction.
- Read latency: AR handshake in cycle T, first rvalid in T+2. With rready held high, one beat per cycle; an N-beat burst finishes its last beat in T+N+1.
- Next AR is accepted the cycle after the last R handshake.
- wready=1 throughout W_DATA. Zero-bubble write: AW in T, beats in T+1..T+N, bvalid from T+N+1.
- rvalid and bvalid, once high, hold their payload stable until the handshake.
- Reset asserted mid-burst aborts both bursts with no further beats or responses; the partially written memory is kept.

## Test plan
- Write 4 beats (awaddr 0x40, awlen 3, wstrb all ones, data k+1), then read 4 beats from 0x40 -> rdata 1,2,3,4; rlast on beat 4 only; rresp 0; bresp 0; first rvalid 2 cycles after AR.
- Partial strobe: write word 0 = all 0xFF, then write wstrb=0x0000_0001 data 0 -> read word 0 = 0xFF..FF00.
- Random rready toggling on a 256-beat read (arlen 255) -> 256 beats in order, no drops or duplicates, payload stable while stalled.
- arburst=2'b00 with arlen 1 -> 2 beats, rresp 2'b10, rdata 0. Write with wlast on beat 2 of 4 -> 4 beats consumed, bresp 2'b10.
- Address wrap: write at word DEPTH-1 with awlen 1 -> second beat lands at word 0; read back confirms.
- Assert rstn low for 1 cycle during beat 3 of a read -> rvalid 0 the next cycle; arready 1 after release; new read returns correct data.

Source files
------------

// File: rtl/spmv_hbm_resp_mem.sv
// BRAM-backed AXI4 subordinate standing in for one HBM pseudo-channel.
// Independent read and write FSMs serve INCR bursts of 256-bit beats from an on-chip word array.
module spmv_hbm_resp_mem #(
  parameter int ADDR_W = 48,
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [1:0]          s_axi_arburst,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [1:0]          s_axi_awburst,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  r_state_t          r_state, r_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_len;
  logic              r_err;
  logic [8:0]        r_issued;
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic [1:0]        fifo_err;
  logic              fifo_wptr, fifo_rptr;
  logic [1:0]        fifo_cnt;
  logic              ar_hs, r_pop, r_issue, r_final_hs;

  w_state_t          w_state, w_state_nxt;
  logic [IDX_W-1:0]  w_idx;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic              w_err, w_bad;
  logic              aw_hs, w_hs, w_final, b_hs;

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr[ADDR_W-1:5+IDX_W], s_axi_araddr[4:0],
                              s_axi_awaddr[ADDR_W-1:5+IDX_W], s_axi_awaddr[4:0]};

  assign ar_hs      = s_axi_arvalid && s_axi_arready;
  assign r_pop      = s_axi_rvalid && s_axi_rready;
  assign r_final_hs = r_pop && fifo_last[fifo_rptr];
  // A beat is fetched only when the 2-entry buffer is guaranteed a free slot at the next edge.
  assign r_issue    = (r_state == R_BURST) && (r_issued <= {1'b0, r_len}) &&
                      ((fifo_cnt != 2'd2) || r_pop);

  always_comb begin
    r_state_nxt   = r_state;
    s_axi_arready = rstn && (r_state == R_IDLE);
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_BURST;
      R_BURST: if (r_final_hs) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= R_IDLE;
      r_issued  <= '0;
      fifo_wptr <= 1'b0;
      fifo_rptr <= 1'b0;
      fifo_cnt  <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (ar_hs) begin
        r_idx    <= s_axi_araddr[5+IDX_W-1:5];
        r_len    <= s_axi_arlen;
        r_err    <= !((s_axi_arburst == 2'b01) && (s_axi_arsize == 3'd5));
        r_issued <= '0;
      end
      if (r_issue) begin
        r_idx                <= r_idx + 1'b1;
        r_issued             <= r_issued + 9'd1;
        fifo_last[fifo_wptr] <= (r_issued[7:0] == r_len);
        fifo_err[fifo_wptr]  <= r_err;
        fifo_wptr            <= ~fifo_wptr;
      end
      if (r_pop) fifo_rptr <= ~fifo_rptr;
      case ({r_issue, r_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign s_axi_rvalid = rstn && (fifo_cnt != 2'd0);
  assign s_axi_rdata  = s_axi_rvalid ? fifo_data[fifo_rptr] : '0;
  assign s_axi_rresp  = (s_axi_rvalid && fifo_err[fifo_rptr]) ? 2'b10 : 2'b00;
  assign s_axi_rlast  = s_axi_rvalid && fifo_last[fifo_rptr];

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign w_final = w_hs && (w_cnt == w_len);
  assign b_hs    = s_axi_bvalid && s_axi_bready;

  always_comb begin
    w_state_nxt   = w_state;
    s_axi_awready = rstn && (w_state == W_IDLE);
    s_axi_wready  = rstn && (w_state == W_DATA);
    s_axi_bvalid  = rstn && (w_state == W_RESP);
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_final) w_state_nxt = W_RESP;
      W_RESP:  if (b_hs) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // Beat count ends the burst; a wlast that disagrees only poisons the response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_bad   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_hs) begin
        w_idx <= s_axi_awaddr[5+IDX_W-1:5];
        w_len <= s_axi_awlen;
        w_cnt <= '0;
        w_err <= !((s_axi_awburst == 2'b01) && (s_axi_awsize == 3'd5));
        w_bad <= !((s_axi_awburst == 2'b01) && (s_axi_awsize == 3'd5));
      end
      if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 8'd1;
        if (s_axi_wlast != (w_cnt == w_len)) w_bad <= 1'b1;
      end
    end
  end

  assign s_axi_bresp = (s_axi_bvalid && w_bad) ? 2'b10 : 2'b00;

  // Read and write share one block so a same-word access returns the old contents.
  always_ff @(posedge clk) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
    if (r_issue) fifo_data[fifo_wptr] <= r_err ? '0 : mem[r_idx];
  end

endmodule
